imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Registered immediate-generation stage between IFU and IDU/EXU. It decodes the immediate format from the opcode
//  itself (no external extop), sign-extends to XLEN, and special-cases shift amounts. Output is valid/ready,
//  with an optional 2-entry skid buffer so in_ready carries no combinational path from out_ready.
// PARAMETERS
//  XLEN  32  datapath width; legal values 32 or 64
//  PC_W  32  width of the pc sideband carried alongside the instruction
//  SKID  1   1: two-entry skid buffer, in_ready registered; 0: single register, in_ready = !out_valid | out_ready
// PORTS
//  clk          in   1     clock; all state changes on the rising edge
//  rst          in   1     reset; synchronous, active-high
//  flush        in   1     synchronous pipeline flush (branch redirect)
//  in_valid     in   1     upstream instruction valid
//  in_ready     out  1     stage can accept this cycle
//  in_inst      in   32    instruction word
//  in_pc        in   PC_W  instruction address
//  out_valid    out  1     out_* fields hold a decoded instruction
//  out_ready    in   1     downstream accepts this cycle
//  out_inst     out  32    instruction, passed through unchanged
//  out_pc       out  PC_W  pc, passed through unchanged
//  out_imm      out  XLEN  extended immediate
//  out_fmt      out  3     0=I 1=U 2=S 3=B 4=J 7=NONE
//  out_illegal  out  1     inst[1:0]!=2'b11 or unknown opcode
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=0 while rst is high, out_imm=0, out_fmt=7, out_illegal=0, out_inst=0, out_pc=0.
//   in_ready=1 in the first cycle after rst deasserts. rst mid-transfer drops all held entries.
//  Format decode (opcode=inst[6:0]):
//   - I: 0000011, 0010011, 1100111, 1110011, 0001111, plus 0011011 when XLEN=64
//   - S: 0100011; B: 1100011; U: 0110111, 0010111; J: 1101111
//   - NONE, imm=0: 0110011, and 0111011 when XLEN=64
//   - Anything else: fmt=NONE, imm=0, illegal=1
//   - inst[1:0]!=2'b11 forces illegal=1 and fmt=NONE
//  Immediates, sign bit inst[31] replicated to XLEN:
//   - I = inst[31:20]
//   - S = {inst[31:25],inst[11:7]}
//   - B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}
//   - J = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}
//   - U = {inst[31:12],12'b0}, sign-extended above bit 31 when XLEN=64
//  Shift special case: for opcode 0010011 with funct3 001 or 101, imm = zero-extended shamt.
//   - shamt is inst[25:20] when XLEN=64, else inst[24:20]
//   - for 0011011 (XLEN=64) shamt is always inst[24:20]
//  Handshake:
//   - input transfer when in_valid&in_ready; output transfer when out_valid&out_ready
//   - latency is exactly 1 cycle from input transfer to out_valid when empty
//   - out_* are stable while out_valid & !out_ready; in-order, no drop, no duplication
//  SKID=1 FSM (main register M drives out_*; skid register K):
//   - EMPTY: in xfer -> ONE
//   - ONE: in xfer & !out_ready -> TWO (data into K); in xfer & out_ready -> ONE (M reloads)
//     !in xfer & out_ready -> EMPTY
//   - TWO: in_ready=0; out_ready -> ONE (M<=K)
//   - in_ready = (state!=TWO), registered
//  Flush:
//   - all entries invalidated next edge, state -> EMPTY
//   - an input presented in the flush cycle is not accepted (in_ready=0 while flush=1)
//   - flush & rst together behave as rst
// STRUCTURE
//  Shared package imm_pkg:
//   - FMT_I/U/S/B/J/NONE localparams
//   - opcode constants OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_FENCE, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OP32
//  One sub-module imm_decode (pure combinational, parameter XLEN): inst -> {imm, fmt, illegal}, instantiated once on the input side;
//   registers hold decoded results, so the output path is register-only.
// TESTING
//  1 Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, out_fmt=7; in_ready=1 the cycle after release.
//  2 Formats (XLEN=32, out_ready=1):
//    - addi x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF, fmt=0
//    - sw (0xFE112E23) -> imm=0xFFFFFFFC, fmt=2
//    - beq (0xFE000EE3) -> imm=0xFFFFFFFC, fmt=3
//    - jal (0x0080006F) -> imm=8, fmt=4
//    - lui (0x123450B7) -> imm=0x12345000, fmt=1
//    - add (0x002081B3) -> imm=0, fmt=7, illegal=0
//  3 XLEN=64:
//    - slli x1,x1,63 (0x03F09093) -> imm=0x3F
//    - lui 0x80000 (0x800000B7) -> imm=0xFFFFFFFF80000000
//    - opcode 0x7F -> illegal=1, fmt=7
//  4 Backpressure (SKID=1): stream 4 insts, out_ready low 2 cycles -> state TWO, in_ready=0;
//    all 4 emerge in order, none lost or duplicated, out_* stable while stalled.
//  5 Flush in state TWO with in_valid=1 -> next cycle out_valid=0, state EMPTY, the presented inst not accepted.
//  6 Random valid/ready for 10k cycles, SKID=0 and SKID=1 -> scoreboard matches reference decode,
//    throughput 1/cycle when out_ready=1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage: format codes, RV opcodes, skid FSM states.
package imm_pkg;

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_U    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: opcode -> format, sign-extended immediate, illegal flag.
// Shift-immediates return the zero-extended shamt instead of the I-type field.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        is_shift;
  logic        sh_hi;
  logic [31:0] imm32;

  assign op       = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign sh_hi    = (XLEN == 64) ? inst[25] : 1'b0;

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    imm32   = '0;
    case (op)
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_IMM: begin
        fmt   = FMT_I;
        imm32 = is_shift ? {26'd0, sh_hi, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          // word shifts only ever have a 5-bit shamt
          fmt   = FMT_I;
          imm32 = is_shift ? {27'd0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'd0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_OP: begin
        fmt = FMT_NONE;
      end
      OP_OP32: begin
        illegal = (XLEN != 64);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
      fmt     = FMT_NONE;
      imm32   = '0;
    end
  end

  // shamt values have bit 31 clear, so plain sign extension also zero-extends them
  assign imm = XLEN'({{32{imm32[31]}}, imm32});

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode on the input side, register-only outputs,
// valid/ready handshake with either a 2-entry skid (registered in_ready) or a single register.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  localparam entry_t RST_ENTRY = '{inst: '0, pc: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  entry_t          in_entry;
  entry_t          main_q;
  logic            rdy_q;
  logic            in_xfer;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_entry = '{inst: in_inst, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};
  assign in_xfer  = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e state;
      entry_t      skid_q;

      // rdy_q is the registered "not full" flag; flush/rst only ever pull it low
      assign in_ready  = rdy_q & ~flush & ~rst;
      assign out_valid = (state != ST_EMPTY);

      always_ff @(posedge clk) begin
        if (rst) begin
          state  <= ST_EMPTY;
          main_q <= RST_ENTRY;
          skid_q <= RST_ENTRY;
          rdy_q  <= 1'b0;
        end else if (flush) begin
          state <= ST_EMPTY;
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= !(state == ST_TWO && !out_ready);
          case (state)
            ST_EMPTY: begin
              if (in_xfer) begin
                main_q <= in_entry;
                state  <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (in_xfer && !out_ready) begin
                skid_q <= in_entry;
                state  <= ST_TWO;
                rdy_q  <= 1'b0;
              end else if (in_xfer) begin
                main_q <= in_entry;
              end else if (out_ready) begin
                state <= ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (out_ready) begin
                main_q <= skid_q;
                state  <= ST_ONE;
              end
            end
            default: state <= ST_EMPTY;
          endcase
        end
      end
    end else begin : g_single
      logic vld_q;

      assign in_ready  = rdy_q & ~flush & ~rst & (~vld_q | out_ready);
      assign out_valid = vld_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          main_q <= RST_ENTRY;
          rdy_q  <= 1'b0;
        end else begin
          rdy_q <= 1'b1;
          if (flush) begin
            vld_q <= 1'b0;
          end else if (in_xfer) begin
            main_q <= in_entry;
            vld_q  <= 1'b1;
          end else if (out_ready) begin
            vld_q <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (X32/skid, X64/skid, X32/single) against a queue scoreboard
// and an arithmetic reference decoder; directed format, reset, backpressure and flush cases plus random traffic.
module tb_imm_gen_stage;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        iv     [N];
  logic [31:0] inst   [N];
  logic [31:0] pc     [N];
  logic        ordy   [N];
  logic        ir     [N];
  logic        ov     [N];
  logic [31:0] o_inst [N];
  logic [31:0] o_pc   [N];
  logic [63:0] o_imm  [N];
  logic [2:0]  o_fmt  [N];
  logic        o_ill  [N];
  logic [31:0] imm_a, imm_c;
  logic [63:0] imm_b;

  imm_gen_stage #(.XLEN(32), .PC_W(32), .SKID(1)) u_dut_x32_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]), .in_inst(inst[0]),
    .in_pc(pc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_inst(o_inst[0]), .out_pc(o_pc[0]),
    .out_imm(imm_a), .out_fmt(o_fmt[0]), .out_illegal(o_ill[0]));

  imm_gen_stage #(.XLEN(64), .PC_W(32), .SKID(1)) u_dut_x64_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]), .in_inst(inst[1]),
    .in_pc(pc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_inst(o_inst[1]), .out_pc(o_pc[1]),
    .out_imm(imm_b), .out_fmt(o_fmt[1]), .out_illegal(o_ill[1]));

  imm_gen_stage #(.XLEN(32), .PC_W(32), .SKID(0)) u_dut_x32_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]), .in_inst(inst[2]),
    .in_pc(pc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_inst(o_inst[2]), .out_pc(o_pc[2]),
    .out_imm(imm_c), .out_fmt(o_fmt[2]), .out_illegal(o_ill[2]));

  assign o_imm[0] = {32'd0, imm_a};
  assign o_imm[1] = imm_b;
  assign o_imm[2] = {32'd0, imm_c};

  int xlen_of [N] = '{32, 64, 32};
  int skid_of [N] = '{1, 1, 0};

  int          n_vec, n_err;
  logic [31:0] sb_inst [N][64];
  logic [31:0] sb_pc   [N][64];
  int          hd [N];
  int          tl [N];
  int          pops [N];
  bit          acc [N];
  bit          live;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = ~64'd0 << bits;
    return v[bits-1] ? (v | m) : v;
  endfunction

  // Reference decode built from field arithmetic on the instruction word.
  function automatic void ref_decode(input logic [31:0] i, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    logic [63:0] x;
    logic [2:0]  f3;
    bit          shift;
    f3    = i[14:12];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    imm   = 64'd0;
    fmt   = 3'd7;
    ill   = 1'b0;
    case (i[6:0])
      7'h03, 7'h67, 7'h73, 7'h0F: begin fmt = 3'd0; imm = sext(64'(i[31:20]), 12); end
      7'h13: begin
        fmt = 3'd0;
        if (shift) imm = (xlen == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
        else       imm = sext(64'(i[31:20]), 12);
      end
      7'h1B: begin
        if (xlen == 64) begin
          fmt = 3'd0;
          imm = shift ? 64'(i[24:20]) : sext(64'(i[31:20]), 12);
        end else ill = 1'b1;
      end
      7'h23: begin fmt = 3'd2; imm = sext(64'(i[31:25]) * 32 + 64'(i[11:7]), 12); end
      7'h63: begin
        fmt = 3'd3;
        x = 64'(i[31]) * 4096 + 64'(i[7]) * 2048 + 64'(i[30:25]) * 32 + 64'(i[11:8]) * 2;
        imm = sext(x, 13);
      end
      7'h37, 7'h17: begin fmt = 3'd1; imm = sext(64'(i[31:12]) * 4096, 32); end
      7'h6F: begin
        fmt = 3'd4;
        x = 64'(i[31]) * 64'd1048576 + 64'(i[19:12]) * 4096 + 64'(i[20]) * 2048 + 64'(i[30:21]) * 2;
        imm = sext(x, 21);
      end
      7'h33: fmt = 3'd7;
      7'h3B: ill = (xlen != 64);
      default: ill = 1'b1;
    endcase
    if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [15];
    logic [31:0] r;
    int          s;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h5B};
    r = $urandom;
    s = $urandom_range(0, 16);
    if (s < 15) r[6:0] = ops[s];
    return r;
  endfunction

  // Inputs are already driven; checks the outputs against the scoreboard, predicts the coming edge,
  // then advances to the next falling edge.
  task automatic step();
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    bit          e_rdy;
    int          cnt, h;
    #1;
    for (int k = 0; k < N; k++) begin
      cnt    = tl[k] - hd[k];
      acc[k] = 1'b0;
      chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(cnt != 0));
      e_rdy = live && !rst && !flush && ((skid_of[k] != 0) ? (cnt < 2) : (cnt == 0 || ordy[k]));
      chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(e_rdy));
      if (cnt != 0 && ov[k] === 1'b1) begin
        h = hd[k] % 64;
        ref_decode(sb_inst[k][h], xlen_of[k], e_imm, e_fmt, e_ill);
        chk($sformatf("out_inst%0d", k), 64'(o_inst[k]), 64'(sb_inst[k][h]));
        chk($sformatf("out_pc%0d", k), 64'(o_pc[k]), 64'(sb_pc[k][h]));
        chk($sformatf("out_imm%0d", k), o_imm[k], e_imm);
        chk($sformatf("out_fmt%0d", k), 64'(o_fmt[k]), 64'(e_fmt));
        chk($sformatf("out_illegal%0d", k), 64'(o_ill[k]), 64'(e_ill));
        if (ordy[k]) begin
          hd[k]++;
          pops[k]++;
        end
      end
      if (rst || flush) begin
        hd[k] = tl[k];
      end else if (iv[k] && e_rdy) begin
        sb_inst[k][tl[k] % 64] = inst[k];
        sb_pc[k][tl[k] % 64]   = pc[k];
        tl[k]++;
        acc[k] = 1'b1;
      end
    end
    live = !rst;
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (3) step();
  endtask

  task automatic directed(input int k, input logic [31:0] ins, input logic [63:0] e_imm,
                          input logic [2:0] e_fmt, input logic e_ill);
    iv[k]   = 1'b1;
    inst[k] = ins;
    pc[k]   = $urandom;
    ordy[k] = 1'b1;
    step();
    iv[k] = 1'b0;
    #1;
    chk($sformatf("dir_valid_%h", ins), 64'(ov[k]), 64'd1);
    chk($sformatf("dir_imm_%h", ins), o_imm[k], e_imm);
    chk($sformatf("dir_fmt_%h", ins), 64'(o_fmt[k]), 64'(e_fmt));
    chk($sformatf("dir_illegal_%h", ins), 64'(o_ill[k]), 64'(e_ill));
    step();
  endtask

  logic [31:0] bp_list [4] = '{32'h00500093, 32'hFE112E23, 32'h123450B7, 32'h0080006F};

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    live  = 1'b0;
    rst   = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b1; inst[k] = 32'h00000013; pc[k] = 32'h100; ordy[k] = 1'b1;
      hd[k] = 0; tl[k] = 0; pops[k] = 0; acc[k] = 1'b0;
    end
    @(negedge clk);

    // reset held with valid input
    repeat (3) begin
      #1;
      for (int k = 0; k < N; k++) begin
        chk($sformatf("rst_fmt%0d", k), 64'(o_fmt[k]), 64'd7);
        chk($sformatf("rst_imm%0d", k), o_imm[k], 64'd0);
        chk($sformatf("rst_illegal%0d", k), 64'(o_ill[k]), 64'd0);
        chk($sformatf("rst_inst%0d", k), 64'(o_inst[k]), 64'd0);
        chk($sformatf("rst_pc%0d", k), 64'(o_pc[k]), 64'd0);
      end
      step();
    end
    rst = 1'b0;
    step();
    #1;
    chk("rel_in_ready", 64'(ir[0]), 64'd1);
    step();
    idle_all();

    // formats, XLEN=32
    directed(0, 32'hFFF00093, 64'hFFFFFFFF, 3'd0, 1'b0);
    directed(0, 32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0);
    directed(0, 32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0);
    directed(0, 32'h0080006F, 64'h8, 3'd4, 1'b0);
    directed(0, 32'h123450B7, 64'h12345000, 3'd1, 1'b0);
    directed(0, 32'h002081B3, 64'h0, 3'd7, 1'b0);
    directed(2, 32'h03F09093, 64'h1F, 3'd0, 1'b0);
    directed(2, 32'h0000007F, 64'h0, 3'd7, 1'b1);
    // XLEN=64
    directed(1, 32'h03F09093, 64'h3F, 3'd0, 1'b0);
    directed(1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd1, 1'b0);
    directed(1, 32'h0000007F, 64'h0, 3'd7, 1'b1);
    directed(1, 32'h03F0909B, 64'h1F, 3'd0, 1'b0);
    idle_all();

    // backpressure: out_ready low for the first two cycles of a 4-instruction stream
    n = 0;
    pops[0] = 0;
    for (int c = 0; c < 20 && pops[0] < 4; c++) begin
      iv[0]   = (n < 4);
      inst[0] = (n < 4) ? bp_list[n] : 32'h0;
      pc[0]   = 32'h1000 + 32'(4 * n);
      ordy[0] = (c >= 2);
      #1;
      if (c == 2) chk("bp_two_in_ready", 64'(ir[0]), 64'd0);
      step();
      if (acc[0]) n++;
    end
    chk("bp_delivered", 64'(pops[0]), 64'd4);
    idle_all();

    // flush while full, with a new instruction presented
    ordy[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      iv[0] = 1'b1; inst[0] = rand_inst(); pc[0] = $urandom;
      step();
    end
    flush   = 1'b1;
    inst[0] = 32'hFFF00093;
    #1;
    chk("flush_in_ready", 64'(ir[0]), 64'd0);
    step();
    flush = 1'b0;
    iv[0] = 1'b0;
    #1;
    chk("flush_out_valid", 64'(ov[0]), 64'd0);
    step();
    idle_all();

    // full-rate streaming
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N; k++) begin
        iv[k] = 1'b1; inst[k] = rand_inst(); pc[k] = $urandom; ordy[k] = 1'b1;
      end
      #1;
      if (c >= 1) begin
        for (int k = 0; k < N; k++) begin
          chk($sformatf("thru_in_ready%0d", k), 64'(ir[k]), 64'd1);
          chk($sformatf("thru_out_valid%0d", k), 64'(ov[k]), 64'd1);
        end
      end
      step();
    end
    idle_all();

    // random traffic with occasional flush and reset
    for (int c = 0; c < 10000; c++) begin
      rst   = ($urandom_range(0, 999) == 0);
      flush = !rst && ($urandom_range(0, 63) == 0);
      for (int k = 0; k < N; k++) begin
        if (!(iv[k] && !acc[k])) begin
          iv[k]   = ($urandom_range(0, 3) != 0);
          inst[k] = rand_inst();
          pc[k]   = $urandom;
        end
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    idle_all();
    for (int k = 0; k < N; k++) chk($sformatf("final_empty%0d", k), 64'(tl[k] - hd[k]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
